// File: rtl/dcache_responder.sv
// Direct-mapped, write-through, no-write-allocate L1 data cache that answers
// load/store requests from the memory stage and services load misses and
// write-throughs over a req/ack handshake to main memory.
module dcache_responder #(
    parameter int LINES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        data_ready,
    output logic [31:0] data_response,
    output logic        busy,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    localparam int IDX_BITS = $clog2(LINES);
    localparam int TAG_BITS = 32 - IDX_BITS - 2;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        WRITE
    } state_t;

    state_t state;

    logic [LINES-1:0]    valid_bits;
    logic [TAG_BITS-1:0] tag_mem  [LINES];
    logic [31:0]         data_mem [LINES];

    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;

    logic [IDX_BITS-1:0] req_idx;
    logic [TAG_BITS-1:0] req_tag;
    logic [IDX_BITS-1:0] lat_idx;
    logic [TAG_BITS-1:0] lat_tag;

    logic hit;
    logic idle_load;
    logic idle_store;
    logic load_hit;
    logic load_miss;
    logic fill_done;
    logic write_done;
    logic unused_addr_bits;

    // Byte offset bits are ignored because every access is a full word.
    assign unused_addr_bits = ^req_addr[1:0];

    assign req_idx = req_addr[IDX_BITS+1:2];
    assign req_tag = req_addr[31:IDX_BITS+2];
    assign lat_idx = lat_addr[IDX_BITS+1:2];
    assign lat_tag = lat_addr[31:IDX_BITS+2];

    assign hit = valid_bits[req_idx] && (tag_mem[req_idx] == req_tag);

    // Requests are only accepted in IDLE, and reset masks everything so that
    // nothing is acknowledged or counted in a cycle that is being reset.
    assign idle_load  = !reset && (state == IDLE) && req_valid && !req_write;
    assign idle_store = !reset && (state == IDLE) && req_valid &&  req_write;
    assign load_hit   = idle_load && hit;
    assign load_miss  = idle_load && !hit;
    assign fill_done  = !reset && (state == FILL)  && mem_ack;
    assign write_done = !reset && (state == WRITE) && mem_ack;

    // Load hits answer in the same cycle; stores complete on the memory ack.
    always_comb begin
        data_ready    = 1'b0;
        data_response = 32'd0;
        if (load_hit) begin
            data_ready    = 1'b1;
            data_response = data_mem[req_idx];
        end else if (write_done && req_valid) begin
            data_ready    = 1'b1;
        end
    end

    // Memory-side outputs come straight from the state register and the
    // latched transaction, so they stay stable until the ack.
    always_comb begin
        busy      = (state != IDLE);
        mem_req   = (state != IDLE);
        mem_we    = (state == WRITE);
        mem_addr  = lat_addr;
        mem_wdata = lat_wdata;
    end

    // Controller: state, valid bits, latched transaction and counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            valid_bits <= '0;
            lat_addr   <= 32'd0;
            lat_wdata  <= 32'd0;
            hit_count  <= 32'd0;
            miss_count <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_hit) begin
                        hit_count <= hit_count + 32'd1;
                    end else if (load_miss) begin
                        miss_count <= miss_count + 32'd1;
                        lat_addr   <= {req_addr[31:2], 2'b00};
                        state      <= FILL;
                    end else if (idle_store) begin
                        lat_addr  <= {req_addr[31:2], 2'b00};
                        lat_wdata <= req_wdata;
                        state     <= WRITE;
                    end
                end
                FILL: begin
                    if (mem_ack) begin
                        valid_bits[lat_idx] <= 1'b1;
                        state               <= IDLE;
                    end
                end
                WRITE: begin
                    if (mem_ack) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tag and data arrays: refilled on a completed miss, patched by store hits.
    always_ff @(posedge clk) begin
        if (fill_done) begin
            tag_mem[lat_idx]  <= lat_tag;
            data_mem[lat_idx] <= mem_rdata;
        end else if (idle_store && hit) begin
            data_mem[req_idx] <= req_wdata;
        end
    end

endmodule

// File: tb/tb_dcache_responder.sv
// Directed testbench for dcache_responder: a cycle-by-cycle vector table for
// the main load/store/eviction flow plus hand-written reset and
// address-change sequences.
module tb_dcache_responder;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        data_ready;
    logic [31:0] data_response;
    logic        busy;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    int compared;
    int mismatched;

    typedef struct {
        logic        v;
        logic        w;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        ack;
        logic [31:0] rdata;
        logic        e_ready;
        logic [31:0] e_resp;
        logic        e_mreq;
        logic        e_mwe;
        logic [31:0] e_maddr;
        logic [31:0] e_mwdata;
        logic        e_busy;
        logic [31:0] e_hit;
        logic [31:0] e_miss;
    } vec_t;

    vec_t vecs[$];

    dcache_responder #(.LINES(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_write     (req_write),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .data_ready    (data_ready),
        .data_response (data_response),
        .busy          (busy),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata),
        .hit_count     (hit_count),
        .miss_count    (miss_count)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Drives one cycle of inputs just after the rising edge, then waits for
    // the falling edge where outputs are sampled.
    task automatic applyStimulus(input logic rst, input logic v, input logic w,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic ack, input logic [31:0] rdata);
        @(posedge clk);
        #1;
        reset     = rst;
        req_valid = v;
        req_write = w;
        req_addr  = addr;
        req_wdata = wdata;
        mem_ack   = ack;
        mem_rdata = rdata;
        @(negedge clk);
    endtask

    task automatic addVec(input logic v, input logic w, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic ack, input logic [31:0] rdata,
                          input logic e_ready, input logic [31:0] e_resp,
                          input logic e_mreq, input logic e_mwe, input logic [31:0] e_maddr,
                          input logic [31:0] e_mwdata, input logic e_busy,
                          input logic [31:0] e_hit, input logic [31:0] e_miss);
        vec_t t;
        t.v = v; t.w = w; t.addr = addr; t.wdata = wdata; t.ack = ack; t.rdata = rdata;
        t.e_ready = e_ready; t.e_resp = e_resp; t.e_mreq = e_mreq; t.e_mwe = e_mwe;
        t.e_maddr = e_maddr; t.e_mwdata = e_mwdata; t.e_busy = e_busy;
        t.e_hit = e_hit; t.e_miss = e_miss;
        vecs.push_back(t);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        mem_ack    = 1'b0;
        mem_rdata  = 32'd0;

        //      v  w  addr       wdata        ack rdata         rdy resp          mreq we maddr      mwdata       busy hit miss
        // Load miss on 0x100, ack after three request cycles, then the held load hits.
        addVec(1, 0, 32'h100, 32'h0,        0, 32'h0,        0, 32'h0,        0, 0, 32'h0,    32'h0,        0, 0, 0);
        addVec(1, 0, 32'h100, 32'h0,        0, 32'h0,        0, 32'h0,        1, 0, 32'h100,  32'h0,        1, 0, 1);
        addVec(1, 0, 32'h100, 32'h0,        0, 32'h0,        0, 32'h0,        1, 0, 32'h100,  32'h0,        1, 0, 1);
        addVec(1, 0, 32'h100, 32'h0,        1, 32'hDEADBEEF, 0, 32'h0,        1, 0, 32'h100,  32'h0,        1, 0, 1);
        addVec(1, 0, 32'h100, 32'h0,        0, 32'h0,        1, 32'hDEADBEEF, 0, 0, 32'h0,    32'h0,        0, 0, 1);
        // Store hit on 0x100, write-through, then 0-cycle load hit with new data.
        addVec(1, 1, 32'h100, 32'h12345678, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,    32'h0,        0, 1, 1);
        addVec(1, 1, 32'h100, 32'h12345678, 0, 32'h0,        0, 32'h0,        1, 1, 32'h100,  32'h12345678, 1, 1, 1);
        addVec(1, 1, 32'h100, 32'h12345678, 1, 32'h0,        1, 32'h0,        1, 1, 32'h100,  32'h12345678, 1, 1, 1);
        addVec(1, 0, 32'h100, 32'h0,        0, 32'h0,        1, 32'h12345678, 0, 0, 32'h0,    32'h0,        0, 1, 1);
        // Store miss on 0x200 does not allocate; the following load misses.
        addVec(1, 1, 32'h200, 32'hCAFEF00D, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,    32'h0,        0, 2, 1);
        addVec(1, 1, 32'h200, 32'hCAFEF00D, 1, 32'h0,        1, 32'h0,        1, 1, 32'h200,  32'hCAFEF00D, 1, 2, 1);
        addVec(1, 0, 32'h200, 32'h0,        0, 32'h0,        0, 32'h0,        0, 0, 32'h0,    32'h0,        0, 2, 1);
        addVec(1, 0, 32'h200, 32'h0,        1, 32'h0BADF00D, 0, 32'h0,        1, 0, 32'h200,  32'h0,        1, 2, 2);
        addVec(1, 0, 32'h200, 32'h0,        0, 32'h0,        1, 32'h0BADF00D, 0, 0, 32'h0,    32'h0,        0, 2, 2);
        // Conflict on index 0: 0x100, then 0x140 evicts it, then 0x100 refetches.
        addVec(1, 0, 32'h100, 32'h0,        0, 32'h0,        0, 32'h0,        0, 0, 32'h0,    32'h0,        0, 3, 2);
        addVec(1, 0, 32'h100, 32'h0,        1, 32'h11112222, 0, 32'h0,        1, 0, 32'h100,  32'h0,        1, 3, 3);
        addVec(1, 0, 32'h100, 32'h0,        0, 32'h0,        1, 32'h11112222, 0, 0, 32'h0,    32'h0,        0, 3, 3);
        addVec(1, 0, 32'h140, 32'h0,        0, 32'h0,        0, 32'h0,        0, 0, 32'h0,    32'h0,        0, 4, 3);
        addVec(1, 0, 32'h140, 32'h0,        1, 32'hAAAA5555, 0, 32'h0,        1, 0, 32'h140,  32'h0,        1, 4, 4);
        addVec(1, 0, 32'h140, 32'h0,        0, 32'h0,        1, 32'hAAAA5555, 0, 0, 32'h0,    32'h0,        0, 4, 4);
        addVec(1, 0, 32'h100, 32'h0,        0, 32'h0,        0, 32'h0,        0, 0, 32'h0,    32'h0,        0, 5, 4);
        addVec(1, 0, 32'h100, 32'h0,        1, 32'h11112222, 0, 32'h0,        1, 0, 32'h100,  32'h0,        1, 5, 5);
        addVec(1, 0, 32'h100, 32'h0,        0, 32'h0,        1, 32'h11112222, 0, 0, 32'h0,    32'h0,        0, 5, 5);
        // No request: no data_ready even on a cached address; stray ack in IDLE ignored.
        addVec(0, 0, 32'h100, 32'h0,        0, 32'h0,        0, 32'h0,        0, 0, 32'h0,    32'h0,        0, 6, 5);
        addVec(0, 0, 32'h100, 32'h0,        1, 32'hFFFFFFFF, 0, 32'h0,        0, 0, 32'h0,    32'h0,        0, 6, 5);
        addVec(0, 0, 32'h100, 32'h0,        0, 32'h0,        0, 32'h0,        0, 0, 32'h0,    32'h0,        0, 6, 5);

        // Reset state.
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        checkOutput("reset busy",       {31'd0, busy},       32'd0);
        checkOutput("reset mem_req",    {31'd0, mem_req},    32'd0);
        checkOutput("reset mem_we",     {31'd0, mem_we},     32'd0);
        checkOutput("reset data_ready", {31'd0, data_ready}, 32'd0);
        checkOutput("reset data_resp",  data_response,       32'd0);
        checkOutput("reset mem_addr",   mem_addr,            32'd0);
        checkOutput("reset mem_wdata",  mem_wdata,           32'd0);
        checkOutput("reset hit_count",  hit_count,           32'd0);
        checkOutput("reset miss_count", miss_count,          32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(1'b0, vecs[i].v, vecs[i].w, vecs[i].addr, vecs[i].wdata,
                          vecs[i].ack, vecs[i].rdata);
            checkOutput($sformatf("v%0d data_ready", i), {31'd0, data_ready}, {31'd0, vecs[i].e_ready});
            checkOutput($sformatf("v%0d data_resp", i),  data_response,       vecs[i].e_resp);
            checkOutput($sformatf("v%0d mem_req", i),    {31'd0, mem_req},    {31'd0, vecs[i].e_mreq});
            checkOutput($sformatf("v%0d busy", i),       {31'd0, busy},       {31'd0, vecs[i].e_busy});
            checkOutput($sformatf("v%0d hit_count", i),  hit_count,           vecs[i].e_hit);
            checkOutput($sformatf("v%0d miss_count", i), miss_count,          vecs[i].e_miss);
            if (vecs[i].e_mreq) begin
                checkOutput($sformatf("v%0d mem_we", i),   {31'd0, mem_we}, {31'd0, vecs[i].e_mwe});
                checkOutput($sformatf("v%0d mem_addr", i), mem_addr,        vecs[i].e_maddr);
                if (vecs[i].e_mwe) begin
                    checkOutput($sformatf("v%0d mem_wdata", i), mem_wdata, vecs[i].e_mwdata);
                end
            end
        end

        // Reset during FILL with an ack arriving right after reset.
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h300, 32'h0, 1'b0, 32'h0);
        checkOutput("rstfill miss ready", {31'd0, data_ready}, 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h300, 32'h0, 1'b0, 32'h0);
        checkOutput("rstfill mem_req",  {31'd0, mem_req}, 32'd1);
        checkOutput("rstfill mem_addr", mem_addr,         32'h300);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h300, 32'h0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h99999999);
        checkOutput("rstfill busy",       {31'd0, busy},       32'd0);
        checkOutput("rstfill mem_req0",   {31'd0, mem_req},    32'd0);
        checkOutput("rstfill mem_we",     {31'd0, mem_we},     32'd0);
        checkOutput("rstfill mem_addr0",  mem_addr,            32'd0);
        checkOutput("rstfill mem_wdata0", mem_wdata,           32'd0);
        checkOutput("rstfill data_ready", {31'd0, data_ready}, 32'd0);
        checkOutput("rstfill hit_count",  hit_count,           32'd0);
        checkOutput("rstfill miss_count", miss_count,          32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        checkOutput("rstfill ack ignored busy", {31'd0, busy},    32'd0);
        checkOutput("rstfill ack ignored req",  {31'd0, mem_req}, 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 32'h0);
        checkOutput("rstfill reload misses", {31'd0, data_ready}, 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 32'h0);
        checkOutput("rstfill refill req",  {31'd0, mem_req}, 32'd1);
        checkOutput("rstfill refill addr", mem_addr,         32'h100);
        checkOutput("rstfill miss_count1", miss_count,       32'd1);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h100, 32'h0, 1'b1, 32'h5A5A5A5A);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 32'h0);
        checkOutput("rstfill hit ready", {31'd0, data_ready}, 32'd1);
        checkOutput("rstfill hit data",  data_response,       32'h5A5A5A5A);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        checkOutput("rstfill hit_count1", hit_count, 32'd1);

        // Request address changes during FILL; the latched miss completes.
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 32'h0);
        checkOutput("addrchg miss ready", {31'd0, data_ready}, 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h300, 32'h0, 1'b0, 32'h0);
        checkOutput("addrchg mem_addr a", mem_addr,         32'h100);
        checkOutput("addrchg mem_req a",  {31'd0, mem_req}, 32'd1);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h300, 32'h0, 1'b0, 32'h0);
        checkOutput("addrchg mem_addr b", mem_addr, 32'h100);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h300, 32'h0, 1'b1, 32'h77778888);
        checkOutput("addrchg mem_addr ack", mem_addr,            32'h100);
        checkOutput("addrchg ack ready",    {31'd0, data_ready}, 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 32'h0);
        checkOutput("addrchg 100 ready", {31'd0, data_ready}, 32'd1);
        checkOutput("addrchg 100 data",  data_response,       32'h77778888);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h300, 32'h0, 1'b0, 32'h0);
        checkOutput("addrchg 300 misses", {31'd0, data_ready}, 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h300, 32'h0, 1'b0, 32'h0);
        checkOutput("addrchg 300 addr", mem_addr,   32'h300);
        checkOutput("addrchg misses",   miss_count, 32'd2);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h300, 32'h0, 1'b1, 32'h13579BDF);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h300, 32'h0, 1'b0, 32'h0);
        checkOutput("addrchg 300 data", data_response, 32'h13579BDF);
        checkOutput("addrchg hits",     hit_count,     32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/dcache_responder.md
Name: dcache_responder

Overview:
- Direct-mapped, write-through, no-write-allocate L1 data cache.
- Acts as the responder side of the memory stage's data port: it answers load and store requests with data_ready / data_response.
- Services misses and write-throughs over a simple req/ack handshake to main memory.
- Sits between the memory stage (LSQ) and the backing memory model.

Parameters:
- LINES, 16, number of one-word cache lines (power of 2, ≥2).
- IDX_BITS, $clog2(LINES), index width (derived; not overridden).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- req_valid  in  1  memory stage has a request this cycle
- req_write  in  1  1 = store, 0 = load
- req_addr  in  32  byte address; bits [1:0] ignored (word aligned)
- req_wdata  in  32  store data
- data_ready  out  1  request completed this cycle
- data_response  out  32  load data, valid when data_ready && !req_write
- busy  out  1  FSM not in IDLE
- mem_req  out  1  request to main memory
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  32  word-aligned address to memory
- mem_wdata  out  32  write data to memory
- mem_ack  in  1  memory completes the transaction this cycle
- mem_rdata  in  32  read data, valid with mem_ack
- hit_count  out  32  load hits since reset
- miss_count  out  32  load misses since reset

Behaviour:
- Address split: index = req_addr[IDX_BITS+1:2]; tag = req_addr[31:IDX_BITS+2].
- Storage per line: valid, tag, data.
- Reset (synchronous, active-high, dominates every state, including mid-transaction):
  - All valid bits cleared; FSM goes to IDLE.
  - Counters cleared to 0.
  - mem_req, mem_we, data_ready and busy are 0; mem_addr, mem_wdata and data_response are 0.
  - An outstanding memory transaction is abandoned. A mem_ack arriving after reset is ignored.
- FSM states:
  - IDLE: the only state that accepts requests.
  - FILL: load miss outstanding.
  - WRITE: write-through outstanding.
- IDLE, req_valid && !req_write:
  - Hit (valid && tag match): data_ready=1 and data_response=line data combinationally in the same cycle (0-cycle hit latency). hit_count++ at the clock edge. Stay in IDLE.
  - Miss: data_ready=0. Latch the word address. miss_count++. Go to FILL.
- IDLE, req_valid && req_write:
  - If hit, update line data at the edge. On a miss, leave the cache unchanged (no allocate).
  - Latch address and data. Go to WRITE. data_ready=0 this cycle.
- FILL:
  - mem_req=1, mem_we=0, mem_addr=latched address.
  - On mem_ack: write mem_rdata into the line, set valid and tag, go to IDLE. data_ready stays 0.
  - The requester still holds its load, so it hits on the next IDLE cycle (miss-to-data latency = ack cycle + 1).
- WRITE:
  - mem_req=1, mem_we=1, mem_addr and mem_wdata latched.
  - On mem_ack: data_ready=1 that cycle, go to IDLE.
- Handshake rules:
  - The requester holds req_valid, req_write, req_addr and req_wdata stable until data_ready.
  - Request changes while busy are ignored; the latched transaction completes.
  - mem_req stays asserted, with stable mem_* outputs, until mem_ack.
  - mem_req drops in the cycle after the ack; there are no back-to-back requests without an IDLE cycle.
- Other rules:
  - data_ready is never asserted when req_valid=0.
  - data_response=0 whenever data_ready=0 or on a store.
  - Counters wrap modulo 2^32.
  - Same index, different tag: a fill overwrites the line (direct-mapped eviction). There is no writeback because the cache is write-through.
  - A mem_ack received in IDLE is ignored.

Test Plan:
- Reset, then load 0x100 (miss) with mem_ack after 3 cycles and mem_rdata=0xDEADBEEF -> mem_req held 3 cycles with mem_addr=0x100; data_ready next IDLE cycle with data_response=0xDEADBEEF; miss_count=1, hit_count=1.
- Store 0x100 with 0x12345678 after the fill -> mem_we=1, mem_wdata=0x12345678, data_ready on the ack cycle. A following load of 0x100 hits in 0 cycles and returns 0x12345678 with no mem_req.
- Store to uncached 0x200, then load 0x200 -> store goes through without allocating; the load misses (miss_count increments).
- Conflict (LINES=16): fill 0x100, then load 0x140 (same index) with fill data 0xAAAA5555, then load 0x100 -> the third access misses again and refetches.
- Reset asserted during FILL, with mem_ack arriving the next cycle -> FSM in IDLE, mem_req=0, ack ignored; a load of 0x100 misses; counters restart from 0.
- Change req_addr from 0x100 to 0x300 during FILL -> mem_addr stays 0x100 until ack; the line for 0x100 is filled.
